// File: rtl/food_spawner_pkg.sv
// Shared constants and state encoding for the Snake food spawner.
// The grid pitch, screen bounds and coordinate widths match the VGA renderer and collision logic.
package food_spawner_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int GRID  = 10;
    localparam int X_MIN = 20;
    localparam int X_MAX = 620;
    localparam int Y_MIN = 20;
    localparam int Y_MAX = 460;
    localparam int RST_X = 320;
    localparam int RST_Y = 240;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_QUERY,
        ST_STEP,
        ST_PLACE
    } spawn_state_t;

endpackage

// File: rtl/food_spawner_if.sv
// Signal bundle between the food spawner and its neighbours: the random generator,
// the snake-body occupancy logic, and the renderer/collision consumers.
interface food_spawner_if;
    import food_spawner_pkg::*;

    logic           eat;
    logic [X_W-1:0] rand_x;
    logic [Y_W-1:0] rand_y;
    // Occupancy query: occ_x/occ_y are held stable while occ_req=1; occ_ack is meaningful
    // only while occ_req=1 (it may coincide with the first occ_req cycle), occ_hit is valid
    // with occ_ack, and occ_req drops the cycle after the ack is taken.
    logic           occ_req;
    logic [X_W-1:0] occ_x;
    logic [Y_W-1:0] occ_y;
    logic           occ_ack;
    logic           occ_hit;
    logic [X_W-1:0] food_x;
    logic [Y_W-1:0] food_y;
    logic           food_valid;
    logic           busy;
    logic           spawn_fail;

    modport master (
        input  eat, rand_x, rand_y, occ_ack, occ_hit,
        output occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail
    );

    modport slave (
        output eat, rand_x, rand_y, occ_ack, occ_hit,
        input  occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, spawn_fail
    );

endinterface

// File: rtl/food_spawner_grid_snap.sv
// Combinational snap of one coordinate axis: floor to a GRID multiple, then clamp to [MIN, MAX].
module food_spawner_grid_snap #(
    parameter int W    = 10,
    parameter int GRID = 10,
    parameter int MIN  = 20,
    parameter int MAX  = 620
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] snapped
);

    localparam logic [W-1:0] GRID_V = W'(GRID);
    localparam logic [W-1:0] MIN_V  = W'(MIN);
    localparam logic [W-1:0] MAX_V  = W'(MAX);

    logic [W-1:0] floored;

    always_comb begin
        floored = raw - (raw % GRID_V);
        if (floored < MIN_V) begin
            snapped = MIN_V;
        end else if (floored > MAX_V) begin
            snapped = MAX_V;
        end else begin
            snapped = floored;
        end
    end

endmodule

// File: rtl/food_spawner.sv
// Food spawner: snaps a random coordinate to the grid, scans forward past snake-occupied cells,
// and publishes a stable food position. Define FOOD_RELOCATE_EN to add idle-timeout relocation.
module food_spawner
    import food_spawner_pkg::*;
#(
    parameter int MAX_TRIES = 8
`ifdef FOOD_RELOCATE_EN
    ,
    parameter int unsigned RELOC_CYC = 500000000
`endif
) (
    input  logic          clk,
    input  logic          rst,
    food_spawner_if.master bus,
    output spawn_state_t  state_dbg
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    spawn_state_t   state, state_next;
    logic [X_W-1:0] cand_x, snap_x, step_x, food_x;
    logic [Y_W-1:0] cand_y, snap_y, step_y, food_y;
    logic [TRY_W-1:0] tries;
    logic           pending, food_valid, spawn_fail;
    logic           start, last_try, reloc_trig;

    food_spawner_grid_snap #(.W(X_W), .GRID(GRID), .MIN(X_MIN), .MAX(X_MAX)) u_snap_x (
        .raw(bus.rand_x), .snapped(snap_x)
    );
    food_spawner_grid_snap #(.W(Y_W), .GRID(GRID), .MIN(Y_MIN), .MAX(Y_MAX)) u_snap_y (
        .raw(bus.rand_y), .snapped(snap_y)
    );

`ifdef FOOD_RELOCATE_EN
    logic [31:0] idle_cnt;
    logic        idle_run;

    assign idle_run   = (state == ST_IDLE) && food_valid;
    assign reloc_trig = idle_run && (idle_cnt == 32'(RELOC_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || bus.eat || reloc_trig || !idle_run) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    assign reloc_trig = 1'b0;
`endif

    assign start    = bus.eat || pending || reloc_trig;
    assign last_try = (tries == TRY_W'(MAX_TRIES - 1));

    // Forward scan wraps x to X_MIN on the next row, and the row back to Y_MIN past the bottom.
    always_comb begin
        step_x = cand_x + X_W'(GRID);
        step_y = cand_y;
        if (step_x > X_W'(X_MAX)) begin
            step_x = X_W'(X_MIN);
            step_y = cand_y + Y_W'(GRID);
            if (step_y > Y_W'(Y_MAX)) begin
                step_y = Y_W'(Y_MIN);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_QUERY;
            ST_QUERY: begin
                if (bus.occ_ack) begin
                    state_next = (bus.occ_hit && !last_try) ? ST_STEP : ST_PLACE;
                end
            end
            ST_STEP:   state_next = ST_QUERY;
            ST_PLACE:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SAMPLE;
            cand_x     <= X_W'(RST_X);
            cand_y     <= Y_W'(RST_Y);
            food_x     <= X_W'(RST_X);
            food_y     <= Y_W'(RST_Y);
            food_valid <= 1'b0;
            tries      <= '0;
            pending    <= 1'b0;
            spawn_fail <= 1'b0;
        end else begin
            state      <= state_next;
            spawn_fail <= 1'b0;
            // One-deep: an eat during a spawn is remembered and consumed on the next IDLE.
            pending    <= (pending || bus.eat) && (state != ST_IDLE);
            case (state)
                ST_IDLE: if (start) food_valid <= 1'b0;
                ST_SAMPLE: begin
                    cand_x <= snap_x;
                    cand_y <= snap_y;
                end
                ST_QUERY: begin
                    if (bus.occ_ack && bus.occ_hit) begin
                        tries      <= tries + TRY_W'(1);
                        spawn_fail <= last_try;
                    end
                end
                ST_STEP: begin
                    cand_x <= step_x;
                    cand_y <= step_y;
                end
                ST_PLACE: begin
                    food_x     <= cand_x;
                    food_y     <= cand_y;
                    food_valid <= 1'b1;
                    tries      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.occ_req    = (state == ST_QUERY);
    assign bus.occ_x      = cand_x;
    assign bus.occ_y      = cand_y;
    assign bus.food_x     = food_x;
    assign bus.food_y     = food_y;
    assign bus.food_valid = food_valid;
    assign bus.busy       = (state != ST_IDLE) && !rst;
    assign bus.spawn_fail = spawn_fail;
    assign state_dbg      = state;

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: expected occupancy queries and placements are queued
// by the stimulus and popped by an independent monitor.
module tb_food_spawner;
    import food_spawner_pkg::*;

    logic         clk;
    logic         rst;
    spawn_state_t state_dbg;

    food_spawner_if bus ();

`ifdef FOOD_RELOCATE_EN
    food_spawner #(.RELOC_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));
`else
    food_spawner dut (.clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));
`endif

    logic [18:0] exp_q[$];      // {occ_x, occ_y}
    logic [20:0] place_q[$];    // {spawn_fail count, food_x, food_y}
    logic        hit_q[$];
    int          ack_delay;
    int          n_checks;
    int          n_pass;
    int          spawn_cnt;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_query(input int x, input int y);
        exp_q.push_back({10'(x), 9'(y)});
    endtask

    task automatic push_place(input int fails, input int x, input int y);
        place_q.push_back({2'(fails), 10'(x), 9'(y)});
    endtask

    task automatic do_eat();
        @(negedge clk);
        bus.eat = 1'b1;
        @(negedge clk);
        bus.eat = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.food_valid && cyc < limit);
        if (!bus.food_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_settled(input int limit);
        int stable;
        int cyc;
        stable = 0;
        cyc = 0;
        while (stable < 6 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            stable = (state_dbg == ST_IDLE) ? stable + 1 : 0;
        end
        if (stable < 6) check("settle_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- occupancy responder ----------------
    initial begin : responder
        int waited;
        waited = 0;
        bus.occ_ack = 1'b0;
        bus.occ_hit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.occ_ack = 1'b0;
            bus.occ_hit = 1'b0;
            if (bus.occ_req) begin
                if (waited >= ack_delay) begin
                    bus.occ_ack = 1'b1;
                    bus.occ_hit = (hit_q.size() > 0) ? hit_q.pop_front() : 1'b0;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        prev_valid;
        logic [1:0]  fail_cnt;
        logic [18:0] q;
        logic [20:0] p;
        prev_valid = 1'b0;
        fail_cnt = 2'd0;
        forever begin
            @(negedge clk);
            if (state_dbg == ST_SAMPLE && !rst) spawn_cnt++;
            if (bus.spawn_fail && fail_cnt != 2'd3) fail_cnt++;
            if (bus.occ_req && bus.occ_ack) begin
                if (exp_q.size() == 0) begin
                    check("query_unexpected", {13'd0, bus.occ_x, bus.occ_y}, 32'd0);
                end else begin
                    q = exp_q.pop_front();
                    check("occ_x", 32'(bus.occ_x), 32'(q[18:9]));
                    check("occ_y", 32'(bus.occ_y), 32'(q[8:0]));
                end
            end
            if (bus.food_valid && !prev_valid) begin
                if (place_q.size() == 0) begin
                    check("place_unexpected", {13'd0, bus.food_x, bus.food_y}, 32'd0);
                end else begin
                    p = place_q.pop_front();
                    check("food_x", 32'(bus.food_x), 32'(p[18:9]));
                    check("food_y", 32'(bus.food_y), 32'(p[8:0]));
                    check("fail_pulses", 32'(fail_cnt), 32'(p[20:19]));
                end
                fail_cnt = 2'd0;
            end
            prev_valid = bus.food_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int cyc;
        int base;
        n_checks = 0;
        n_pass = 0;
        spawn_cnt = 0;
        ack_delay = 0;
        rst = 1'b1;
        bus.eat = 1'b0;
        bus.rand_x = 10'd123;
        bus.rand_y = 9'd77;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_food_x", 32'(bus.food_x), 32'd320);
        check("rst_food_y", 32'(bus.food_y), 32'd240);
        check("rst_valid", 32'(bus.food_valid), 32'd0);
        check("rst_occ_req", 32'(bus.occ_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_spawn_fail", 32'(bus.spawn_fail), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_SAMPLE));

        // Automatic spawn after reset: (123,77) -> (120,70)
        push_query(120, 70);
        push_place(0, 120, 70);
        rst = 1'b0;
        wait_valid(10, cyc);
        check("rst_latency_le4", 32'(cyc <= 4), 32'd1);

        // Clamp on both axes, eat latency 4
        bus.rand_x = 10'd5;
        bus.rand_y = 9'd470;
        push_query(20, 460);
        push_place(0, 20, 460);
        do_eat();
        check("eat_valid_drop", 32'(bus.food_valid), 32'd0);
        check("eat_busy", 32'(bus.busy), 32'd1);
        wait_valid(10, cyc);
        check("eat_latency", 32'(cyc + 1), 32'd4);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // x and y wrap after a hit at the bottom-right corner
        bus.rand_x = 10'd625;
        bus.rand_y = 9'd465;
        hit_q.push_back(1'b1);
        hit_q.push_back(1'b0);
        push_query(620, 460);
        push_query(20, 20);
        push_place(0, 20, 20);
        do_eat();
        wait_valid(20, cyc);

        // Every query hits: give up after 8, place the last candidate
        bus.rand_x = 10'd300;
        bus.rand_y = 9'd200;
        for (int i = 0; i < 8; i++) begin
            hit_q.push_back(1'b1);
            push_query(300 + 10 * i, 200);
        end
        push_place(1, 370, 200);
        do_eat();
        wait_valid(40, cyc);
        check("fail_valid", 32'(bus.food_valid), 32'd1);

        // Two eats during a slow spawn: exactly one extra spawn
        ack_delay = 5;
        bus.rand_x = 10'd55;
        bus.rand_y = 9'd55;
        push_query(50, 50);
        push_place(0, 50, 50);
        push_query(50, 50);
        push_place(0, 50, 50);
        base = spawn_cnt;
        do_eat();
        @(negedge clk);
        do_eat();
        do_eat();
        wait_settled(200);
        check("pending_spawns", 32'(spawn_cnt - base), 32'd2);
        check("pending_idle", 32'(state_dbg), 32'(ST_IDLE));

        // Reset in the middle of a query aborts cleanly
        do_eat();
        repeat (2) @(negedge clk);
        check("mid_occ_req", 32'(bus.occ_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_occ_req", 32'(bus.occ_req), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_food_x", 32'(bus.food_x), 32'd320);
        check("abort_food_y", 32'(bus.food_y), 32'd240);
        check("abort_valid", 32'(bus.food_valid), 32'd0);
        @(negedge clk);
        check("abort_occ_req2", 32'(bus.occ_req), 32'd0);
        ack_delay = 0;
        bus.rand_x = 10'd999;
        bus.rand_y = 9'd300;
        push_query(620, 300);
        push_place(0, 620, 300);
        rst = 1'b0;
        wait_valid(10, cyc);

        // Idle relocation
        bus.rand_x = 10'd77;
        bus.rand_y = 9'd33;
        push_query(70, 30);
        push_place(0, 70, 30);
`ifdef FOOD_RELOCATE_EN
        push_query(70, 30);
        push_place(0, 70, 30);
`endif
        base = spawn_cnt;
        do_eat();
        wait_valid(10, cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (state_dbg != ST_SAMPLE && cyc < 40);
`ifdef FOOD_RELOCATE_EN
        check("reloc_delay", 32'(cyc), 32'd16);
        wait_valid(20, cyc);
        check("reloc_spawns", 32'(spawn_cnt - base), 32'd2);
`else
        check("no_reloc_spawns", 32'(spawn_cnt - base), 32'd1);
        check("no_reloc_idle", 32'(state_dbg), 32'(ST_IDLE));
`endif

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("queries_drained", 32'(exp_q.size()), 32'd0);
        check("places_drained", 32'(place_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
